// File: rtl/dense_layer_seq_ctrl.sv
// Sequential dense layer: one signed MAC walks every (neuron, input) pair and emits one result per neuron.
// Optional running argmax over the emitted results is enabled with `define DENSE_SEQ_ARGMAX_EN.
module dense_layer_seq_ctrl #(
    parameter int IN_SIZE  = 32,
    parameter int OUT_SIZE = 3,
    parameter int IN_W     = 56,
    parameter int W_W      = 8,
    parameter int B_W      = 16,
    parameter int ACC_W    = 72
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic [$clog2(IN_SIZE)-1:0]            in_addr,
    input  logic signed [IN_W-1:0]                in_data,
    output logic [$clog2(IN_SIZE*OUT_SIZE)-1:0]   w_addr,
    input  logic signed [W_W-1:0]                 w_data,
    output logic [$clog2(OUT_SIZE)-1:0]           b_addr,
    input  logic signed [B_W-1:0]                 b_data,
    output logic                                  out_valid,
    output logic [$clog2(OUT_SIZE)-1:0]           out_idx,
    output logic signed [ACC_W-1:0]               out_data,
    output logic [$clog2(OUT_SIZE)-1:0]           class_idx,
    output logic                                  class_valid
);

    localparam int IA_W   = $clog2(IN_SIZE);
    localparam int WA_W   = $clog2(IN_SIZE*OUT_SIZE);
    localparam int BA_W   = $clog2(OUT_SIZE);
    localparam int PROD_W = IN_W + W_W;

    localparam logic [IA_W-1:0] K_LAST  = IA_W'(IN_SIZE - 1);
    localparam logic [BA_W-1:0] N_LAST  = BA_W'(OUT_SIZE - 1);
    localparam logic [IA_W-1:0] IA_ZERO = {IA_W{1'b0}};
    localparam logic [IA_W-1:0] IA_ONE  = IA_W'(1);
    localparam logic [WA_W-1:0] WA_ZERO = {WA_W{1'b0}};
    localparam logic [WA_W-1:0] WA_ONE  = WA_W'(1);
    localparam logic [BA_W-1:0] BA_ZERO = {BA_W{1'b0}};
    localparam logic [BA_W-1:0] BA_ONE  = BA_W'(1);
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_MAC, S_EMIT} state_t;

    state_t                  state_q, state_d;
    logic [IA_W-1:0]         in_addr_q, in_addr_d;
    logic [WA_W-1:0]         w_addr_q, w_addr_d;
    logic [BA_W-1:0]         b_addr_q, b_addr_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    out_valid_q, out_valid_d;
    logic [BA_W-1:0]         out_idx_q, out_idx_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;

    logic signed [PROD_W-1:0] in_ext_s, w_ext_s, prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s, bias_ext_s, mac_sum_s;

    // Full-precision product and sign extension into the accumulator width.
    assign in_ext_s   = {{W_W{in_data[IN_W-1]}}, in_data};
    assign w_ext_s    = {{IN_W{w_data[W_W-1]}}, w_data};
    assign prod_s     = in_ext_s * w_ext_s;
    assign prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    assign bias_ext_s = {{(ACC_W-B_W){b_data[B_W-1]}}, b_data};
    assign mac_sum_s  = acc_q + prod_ext_s;

    // Next-state, address sequencing and result capture.
    always_comb begin
        state_d     = state_q;
        in_addr_d   = in_addr_q;
        w_addr_d    = w_addr_q;
        b_addr_d    = b_addr_q;
        acc_d       = acc_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = 1'b0;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FIRST;
                    in_addr_d = IA_ZERO;
                    w_addr_d  = WA_ZERO;
                    b_addr_d  = BA_ZERO;
                    acc_d     = ACC_ZERO;
                    busy_d    = 1'b1;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_FIRST: begin
                acc_d     = bias_ext_s + prod_ext_s;
                in_addr_d = in_addr_q + IA_ONE;
                w_addr_d  = w_addr_q + WA_ONE;
                state_d   = S_MAC;
            end
            S_MAC: begin
                acc_d = mac_sum_s;
                // Addresses stop at the last element so they never leave the valid range.
                if (in_addr_q == K_LAST) begin
                    state_d     = S_EMIT;
                    out_valid_d = 1'b1;
                    out_idx_d   = b_addr_q;
                    out_data_d  = mac_sum_s;
                    done_d      = (b_addr_q == N_LAST);
                end else begin
                    in_addr_d   = in_addr_q + IA_ONE;
                    w_addr_d    = w_addr_q + WA_ONE;
                end
            end
            S_EMIT: begin
                if (b_addr_q == N_LAST) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                end else begin
                    state_d   = S_FIRST;
                    b_addr_d  = b_addr_q + BA_ONE;
                    in_addr_d = IA_ZERO;
                    w_addr_d  = w_addr_q + WA_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters, accumulator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_addr_q   <= IA_ZERO;
            w_addr_q    <= WA_ZERO;
            b_addr_q    <= BA_ZERO;
            acc_q       <= ACC_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= BA_ZERO;
            out_data_q  <= ACC_ZERO;
        end else begin
            state_q     <= state_d;
            in_addr_q   <= in_addr_d;
            w_addr_q    <= w_addr_d;
            b_addr_q    <= b_addr_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign in_addr   = in_addr_q;
    assign w_addr    = w_addr_q;
    assign b_addr    = b_addr_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;

`ifdef DENSE_SEQ_ARGMAX_EN
    logic signed [ACC_W-1:0] max_q, max_d;
    logic [BA_W-1:0]         max_idx_q, max_idx_d;
    logic [BA_W-1:0]         cls_idx_q, cls_idx_d;
    logic                    cls_valid_q, cls_valid_d;
    logic                    take_s;

    // Running maximum; neuron 0 always seeds it and strict compare keeps the lowest index on ties.
    always_comb begin
        max_d       = max_q;
        max_idx_d   = max_idx_q;
        cls_idx_d   = cls_idx_q;
        cls_valid_d = 1'b0;
        take_s      = 1'b0;
        if ((state_q == S_IDLE) && start) begin
            max_d     = ACC_ZERO;
            max_idx_d = BA_ZERO;
        end else if (out_valid_d) begin
            take_s = (b_addr_q == BA_ZERO) || (mac_sum_s > max_q);
            if (take_s) begin
                max_d     = mac_sum_s;
                max_idx_d = b_addr_q;
            end else begin
                max_d     = max_q;
                max_idx_d = max_idx_q;
            end
            if (done_d) begin
                cls_valid_d = 1'b1;
                cls_idx_d   = take_s ? b_addr_q : max_idx_q;
            end else begin
                cls_valid_d = 1'b0;
            end
        end else begin
            cls_valid_d = 1'b0;
        end
    end

    // Argmax registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q       <= ACC_ZERO;
            max_idx_q   <= BA_ZERO;
            cls_idx_q   <= BA_ZERO;
            cls_valid_q <= 1'b0;
        end else begin
            max_q       <= max_d;
            max_idx_q   <= max_idx_d;
            cls_idx_q   <= cls_idx_d;
            cls_valid_q <= cls_valid_d;
        end
    end

    assign class_idx   = cls_idx_q;
    assign class_valid = cls_valid_q;
`else
    assign class_idx   = BA_ZERO;
    assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dense_layer_seq_ctrl.sv
// Directed bench for dense_layer_seq_ctrl: vector table of ROM patterns plus reset, handshake and abort sequences.
module tb_dense_layer_seq_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               busy, done, out_valid, class_valid;
    logic [4:0]         in_addr;
    logic [6:0]         w_addr;
    logic [1:0]         b_addr, out_idx, class_idx;
    logic signed [55:0] in_data;
    logic signed [7:0]  w_data;
    logic signed [15:0] b_data;
    logic signed [71:0] out_data;

    logic signed [55:0] in_mem [32];
    logic signed [7:0]  w_mem  [96];
    logic signed [15:0] b_mem  [3];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int                 pat;
        logic signed [71:0] e0;
        logic signed [71:0] e1;
        logic signed [71:0] e2;
        logic [1:0]         cls;
    } vec_t;

    vec_t vecs [5];

    dense_layer_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data), .out_valid(out_valid), .out_idx(out_idx),
        .out_data(out_data), .class_idx(class_idx), .class_valid(class_valid)
    );

    always #5 clk = ~clk;

    // Read data follows the registered address presented during the previous cycle.
    assign in_data = in_mem[in_addr];
    assign w_data  = w_mem[w_addr];
    assign b_data  = (b_addr < 2'd3) ? b_mem[b_addr] : 16'sd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input int p);
        for (int k = 0; k < 32; k++) begin
            case (p)
                0, 1:    in_mem[k] = 56'(k % 4 + 1);
                2:       in_mem[k] = 56'sh7F_FFFF_FFFF_FFFF;
                default: in_mem[k] = 56'sd1;
            endcase
        end
        for (int i = 0; i < 96; i++) begin
            case (p)
                0:       w_mem[i] = 8'sd1;
                1:       w_mem[i] = (i / 32 == 1) ? -8'sd1 : 8'sd1;
                2:       w_mem[i] = -8'sd128;
                3:       w_mem[i] = 8'sd0;
                default: w_mem[i] = (i / 32 == 2) ? 8'sd1 : 8'sd0;
            endcase
        end
        case (p)
            0:       begin b_mem[0] = 16'sd0;      b_mem[1] = 16'sd0;      b_mem[2] = 16'sd0;      end
            1:       begin b_mem[0] = 16'sd0;      b_mem[1] = 16'sd5;      b_mem[2] = -16'sd128;   end
            2:       begin b_mem[0] = -16'sd32768; b_mem[1] = -16'sd32768; b_mem[2] = -16'sd32768; end
            3:       begin b_mem[0] = 16'sd10;     b_mem[1] = 16'sd50;     b_mem[2] = 16'sd50;     end
            default: begin b_mem[0] = -16'sd9;     b_mem[1] = -16'sd5;     b_mem[2] = -16'sd40;    end
        endcase
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      72'(busy),        72'd0);
        check({tag, "_done"},      72'(done),        72'd0);
        check({tag, "_out_valid"}, 72'(out_valid),   72'd0);
        check({tag, "_out_idx"},   72'(out_idx),     72'd0);
        check({tag, "_out_data"},  out_data,         72'd0);
        check({tag, "_addrs"},     72'({in_addr, w_addr, b_addr}), 72'd0);
        check({tag, "_class"},     72'({class_idx, class_valid}),  72'd0);
    endtask

    // Pulse (or hold) start, then watch every cycle up to last_c for strobes, done and busy.
    task automatic run_vec(input int vi, input bit hold, input int last_c);
        logic signed [71:0] exp_a [3];
        int ns, done_cyc, cyc;
        bit busy_bad;
        exp_a[0] = vecs[vi].e0;
        exp_a[1] = vecs[vi].e1;
        exp_a[2] = vecs[vi].e2;
        load(vecs[vi].pat);
        ns = 0; done_cyc = -1; busy_bad = 1'b0;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int c = 0; c <= last_c; c++) begin
            cyc = c + 1;
            if (hold && c == 99) start = 1'b0;
            if (busy !== ((cyc >= 1 && cyc <= 99) ? 1'b1 : 1'b0)) busy_bad = 1'b1;
            if (out_valid === 1'b1) begin
                if (ns < 3) begin
                    check($sformatf("v%0d_strobe%0d_cycle", vi, ns), 72'(cyc), 72'((ns + 1) * 33));
                    check($sformatf("v%0d_strobe%0d_idx", vi, ns), 72'(out_idx), 72'(ns));
                    check($sformatf("v%0d_strobe%0d_data", vi, ns), out_data, exp_a[ns]);
                end
                ns++;
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
`ifdef DENSE_SEQ_ARGMAX_EN
                check($sformatf("v%0d_class_valid", vi), 72'(class_valid), 72'd1);
                check($sformatf("v%0d_class_idx", vi), 72'(class_idx), 72'(vecs[vi].cls));
`else
                check($sformatf("v%0d_class_tied", vi), 72'({class_idx, class_valid}), 72'd0);
`endif
            end
            if (c < last_c) tick();
        end
        check($sformatf("v%0d_strobe_count", vi), 72'(ns), 72'd3);
        check($sformatf("v%0d_done_cycle", vi), 72'(done_cyc), 72'd99);
        check($sformatf("v%0d_busy_window", vi), 72'(busy_bad), 72'd0);
    endtask

    initial begin
        int stray;
        vecs[0] = '{pat: 0, e0: 72'sd80, e1: 72'sd80,  e2: 72'sd80,  cls: 2'd0};
        vecs[1] = '{pat: 1, e0: 72'sd80, e1: -72'sd75, e2: -72'sd48, cls: 2'd0};
        vecs[2] = '{pat: 2, e0: 72'hF7_FFFF_FFFF_FFFF_9000, e1: 72'hF7_FFFF_FFFF_FFFF_9000,
                    e2: 72'hF7_FFFF_FFFF_FFFF_9000, cls: 2'd0};
        vecs[3] = '{pat: 3, e0: 72'sd10, e1: 72'sd50,  e2: 72'sd50,  cls: 2'd1};
        vecs[4] = '{pat: 4, e0: -72'sd9, e1: -72'sd5,  e2: -72'sd8,  cls: 2'd1};

        rst = 1'b1;
        start = 1'b0;
        load(0);
        #2;
        check_all_zero("reset");
        #10;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_vec(i, 1'b0, 105);
        end

        // start held through the whole run, then a fresh start sampled at cycle 100.
        run_vec(0, 1'b1, 99);
        run_vec(0, 1'b0, 105);

        // Abort at cycle 40 with an asynchronous mid-cycle reset.
        load(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (39) tick();
        check("abort_pre_data", out_data, 72'sd80);
        check("abort_pre_busy", 72'(busy), 72'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        tick();
        tick();
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 110; c++) begin
            tick();
            if (out_valid === 1'b1 || done === 1'b1 || busy === 1'b1) stray++;
        end
        check("abort_no_activity", 72'(stray), 72'd0);
        run_vec(1, 1'b0, 105);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dense_layer_seq_ctrl.md
Name: dense_layer_seq_ctrl

Overview:
Time-multiplexed sequencer for the final dense layer of the speech-recognition network. It computes the layer with one signed MAC instead of a fully parallel combinational array.
- Fetches input activations from the previous layer's buffer, and weights/biases from synchronous ROMs, one element per cycle.
- Accumulates each output neuron in turn and emits one result per neuron.
- Sits between the layer-3 output buffer and the classifier/output stage, under a start/done handshake from the top-level inference FSM.

Parameters:
IN_SIZE, 32, input vector length
OUT_SIZE, 3, number of output neurons
IN_W, 56, signed input activation width
W_W, 8, signed weight width
B_W, 16, signed bias width
ACC_W, 72, signed accumulator/output width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to compute the layer
busy  out  1  high while a computation is in progress
done  out  1  one-cycle pulse, coincident with the last out_valid
in_addr  out  $clog2(IN_SIZE)  input buffer read address (registered)
in_data  in  IN_W  signed activation, valid 1 cycle after in_addr
w_addr  out  $clog2(IN_SIZE*OUT_SIZE)  weight ROM address, n*IN_SIZE+k (registered)
w_data  in  W_W  signed weight, valid 1 cycle after w_addr
b_addr  out  $clog2(OUT_SIZE)  bias ROM address (registered)
b_data  in  B_W  signed bias, valid 1 cycle after b_addr
out_valid  out  1  one-cycle strobe: out_data/out_idx valid
out_idx  out  $clog2(OUT_SIZE)  neuron index of out_data
out_data  out  ACC_W  signed neuron result

Behaviour:
Reset and handshake:
- Reset (async, active-high): state IDLE; all outputs, counters and the accumulator go to 0; no pulse is generated.
- start is sampled only in IDLE. start while busy is ignored, including in the done cycle.

States:
- IDLE: on start, go to FIRST. On the same edge, n=0, k=0, b_addr=0, in_addr=0, w_addr=0. Then busy=1.
- FIRST (1 cycle): acc <= sext(b_data) + sext(in_data*w_data). Advance to k=1.
- MAC (k=1..IN_SIZE-1, 1 cycle each): acc <= acc + sext(in_data*w_data). Addresses advance each cycle. The last MAC goes to EMIT.
- EMIT (1 cycle):
  - out_valid=1, out_idx=n, out_data=acc. These are registered; they hold their value until the next EMIT.
  - If n<OUT_SIZE-1: n++, issue the next neuron's addresses and return to FIRST.
  - Otherwise: done=1, then IDLE with busy=0 on the next cycle.

Timing (start sampled at edge 0):
- Neuron n strobes at cycle (n+1)*(IN_SIZE+1): 33, 66, 99 at the defaults.
- busy is high for cycles 1..99 inclusive.
- A new start is accepted from cycle 100.

Arithmetic:
- Product is full-precision signed (IN_W+W_W bits), sign-extended to ACC_W.
- Bias is sign-extended to ACC_W.
- Accumulation wraps modulo 2^ACC_W; there is no saturation.

Boundaries:
- Reset mid-operation aborts immediately; no out_valid or done follows.
- Address counters never exceed IN_SIZE-1, OUT_SIZE-1 or IN_SIZE*OUT_SIZE-1.

Optional Feature:
Macro DENSE_SEQ_ARGMAX_EN.
- Defined: adds outputs class_idx ($clog2(OUT_SIZE)) and class_valid (1).
  - A running signed maximum is kept over each EMIT; ties resolve to the lowest index.
  - class_valid pulses with done; class_idx holds until the next done.
  - The maximum is cleared on start and on reset.
- Not defined: both ports still exist and are tied to 0; no compare logic is built.

Test Plan:
1. Reset values: assert rst mid-cycle, without a clock edge -> every output reads 0 immediately; busy=0.
2. Basic run: in_data = 1,2,3,4 repeated, all weights 1, biases 0, pulse start -> out_valid at cycles 33/66/99 with out_idx 0/1/2 and out_data 80 each; done at cycle 99; busy low at 100.
3. Signed path: same inputs, neuron-1 weights = -1, bias1 = 5, bias2 = -128 -> out_data = 80, -75, -48.
4. Width/extreme: in_data = 2^55-1, weights = -128, bias = -32768 -> out_data[0] = 32*(-128)*(2^55-1) - 32768, exact in 72 bits.
5. Handshake: start held high through a run -> only one computation; start at cycle 99 ignored; start at cycle 100 starts a second run that gives identical results.
6. Abort plus option: rst at cycle 40 -> no further strobes; a rerun is correct. With DENSE_SEQ_ARGMAX_EN, results 10/50/50 -> class_idx=1 and class_valid at cycle 99.
